des_dec_key_sched: RTL and testbench

//  Sequential DES key schedule for the decrypt direction: takes a 64-bit key and streams the 16 48-bit round

---
 rtl/des_dec_key_sched.sv | 163 ++++++++++++++++
 tb/tb_des_dec_key_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched: sequential DES key schedule.
// The default build streams the 16 round subkeys in decrypt order (K16 first).
// Define DES_KS_ENC_MODE_EN to add an 'encrypt' input that selects forward order (K1 first).
// PARITY_CHK=1 reports an even-parity key byte on parity_err, latched when start is accepted.
module des_dec_key_sched #(
  parameter int PARITY_CHK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        start,
`ifdef DES_KS_ENC_MODE_EN
  input  logic        encrypt,
`endif
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  // PC-1 and PC-2 tables, entries are 1-based DES bit numbers (bit 1 = MSB)
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_reg, state_next;
  logic [55:0] cd_reg, cd_next;
  logic [3:0]  round_reg, round_next;
  logic        parity_reg, parity_next;

  logic [55:0] pc1_key;
  logic [47:0] pc2_cd;
  logic        key_par_err;
  logic [3:0]  idx_next;
  logic        shift_one;
  logic [55:0] cd_step;

  // Bit permutations as pure wiring
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[55-gi] = key_in[64-PC1_TAB[gi]];
    end
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_cd[47-gi] = cd_reg[56-PC2_TAB[gi]];
    end
    if (PARITY_CHK != 0) begin : g_par
      logic [7:0] byte_par;
      for (genvar gi = 0; gi < 8; gi++) begin : g_byte
        assign byte_par[gi] = ^key_in[gi*8 +: 8];
      end
      // A valid DES key byte has odd parity; any even byte flags an error
      assign key_par_err = ~&byte_par;
    end else begin : g_nopar
      assign key_par_err = 1'b0;
    end
  endgenerate

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // Rounds 1, 8 and 15 move by one position, all others by two; this holds
  // for both the decrypt right-shift and the encrypt left-shift tables.
  assign idx_next  = round_reg + 4'd1;
  assign shift_one = (idx_next == 4'd1) || (idx_next == 4'd8) || (idx_next == 4'd15);

`ifdef DES_KS_ENC_MODE_EN
  logic enc_reg;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  // Direction is captured together with the key
  always_ff @(posedge clk) begin
    if (rst)
      enc_reg <= 1'b0;
    else if (state_reg == IDLE && start)
      enc_reg <= encrypt;
  end

  assign cd_step = enc_reg ?
    {rotl(cd_reg[55:28], shift_one), rotl(cd_reg[27:0], shift_one)} :
    {rotr(cd_reg[55:28], shift_one), rotr(cd_reg[27:0], shift_one)};
`else
  assign cd_step = {rotr(cd_reg[55:28], shift_one), rotr(cd_reg[27:0], shift_one)};
`endif

  // State and schedule registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cd_reg     <= 56'h0;
      round_reg  <= 4'd0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cd_reg     <= cd_next;
      round_reg  <= round_next;
      parity_reg <= parity_next;
    end
  end

  // Next-state logic: load on start, advance one round per accepted subkey
  always_comb begin
    state_next  = state_reg;
    cd_next     = cd_reg;
    round_next  = round_reg;
    parity_next = parity_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cd_next     = pc1_key;
          round_next  = 4'd0;
          parity_next = key_par_err;
          state_next  = LOAD;
        end
      end
      LOAD: begin
`ifdef DES_KS_ENC_MODE_EN
        // Forward order needs the first left shift before K1 is presented
        if (enc_reg)
          cd_next = {rotl(cd_reg[55:28], 1'b1), rotl(cd_reg[27:0], 1'b1)};
`endif
        state_next = EMIT;
      end
      EMIT: begin
        if (subkey_ready) begin
          if (round_reg == 4'd15) begin
            state_next = DONE;
          end else begin
            round_next = idx_next;
            cd_next    = cd_step;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign subkey_valid = (state_reg == EMIT);
  assign busy         = (state_reg == LOAD) || (state_reg == EMIT);
  assign done         = (state_reg == DONE);
  assign subkey       = subkey_valid ? pc2_cd : 48'h0;
  assign round_idx    = round_reg;
  assign parity_err   = parity_reg;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed testbench for des_dec_key_sched (decrypt order, stall, parity,
// abort, back-to-back restart; encrypt order when DES_KS_ENC_MODE_EN is set).
module tb_des_dec_key_sched;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h133457799BBCDFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        start;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        parity_err;

  logic [47:0] np_subkey;
  logic        np_subkey_valid;
  logic [3:0]  np_round_idx;
  logic        np_busy;
  logic        np_done;
  logic        np_parity_err;
`ifdef DES_KS_ENC_MODE_EN
  logic        encrypt;
`endif

  int checks = 0;
  int errors = 0;
  logic [47:0] k_tab [16];

  always #5 clk = ~clk;

  des_dec_key_sched #(.PARITY_CHK(1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .start(start),
`ifdef DES_KS_ENC_MODE_EN
    .encrypt(encrypt),
`endif
    .subkey_ready(subkey_ready), .subkey(subkey), .subkey_valid(subkey_valid),
    .round_idx(round_idx), .busy(busy), .done(done), .parity_err(parity_err)
  );

  des_dec_key_sched #(.PARITY_CHK(0)) dut_np (
    .clk(clk), .rst(rst), .key_in(key_in), .start(start),
`ifdef DES_KS_ENC_MODE_EN
    .encrypt(encrypt),
`endif
    .subkey_ready(subkey_ready), .subkey(np_subkey), .subkey_valid(np_subkey_valid),
    .round_idx(np_round_idx), .busy(np_busy), .done(np_done), .parity_err(np_parity_err)
  );

  // One line per subkey transfer
  always @(posedge clk) begin
    if (!rst && subkey_valid && subkey_ready)
      $display("xfer round_idx=%0d subkey=%012h", round_idx, subkey);
  end

  // Present start for exactly one rising edge; returns at the negedge after it (LOAD)
  task automatic start_sched(input logic [63:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key_in = KEY_A; subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (subkey_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", subkey_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", round_idx); end
    checks++; if (subkey !== 48'h0) begin errors++; $display("FAIL reset_subkey got %h want 0", subkey); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", parity_err); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_schedule();
    subkey_ready = 1'b1;
    start_sched(KEY_A);
    key_in = 64'hFFFF_FFFF_FFFF_FFFF;  // must not affect the running schedule
    checks++; if (busy !== 1'b1 || subkey_valid !== 1'b0) begin errors++; $display("FAIL load_state got busy=%b valid=%b want 1 0", busy, subkey_valid); end
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      checks++; if (subkey_valid !== 1'b1) begin errors++; $display("FAIL sched_valid r=%0d got %b want 1", r, subkey_valid); end
      checks++; if (round_idx !== 4'(r)) begin errors++; $display("FAIL sched_round got %0d want %0d", round_idx, r); end
      checks++; if (subkey !== k_tab[15-r]) begin errors++; $display("FAIL sched_subkey r=%0d got %h want %h", r, subkey, k_tab[15-r]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sched_done got done=%b valid=%b busy=%b want 1 0 0", done, subkey_valid, busy); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL sched_parity got %b want 0", parity_err); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  task automatic test_stall();
    subkey_ready = 1'b1;
    start_sched(KEY_A);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      checks++; if (round_idx !== 4'(r) || subkey !== k_tab[15-r]) begin errors++; $display("FAIL stall_seq r=%0d got %0d/%h want %0d/%h", r, round_idx, subkey, r, k_tab[15-r]); end
      if (r == 3) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++; if (subkey_valid !== 1'b1 || round_idx !== 4'd3 || subkey !== k_tab[12]) begin errors++; $display("FAIL stall_hold s=%0d got %b/%0d/%h want 1/3/%h", s, subkey_valid, round_idx, subkey, k_tab[12]); end
        end
        subkey_ready = 1'b1;
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
  endtask

  task automatic test_parity();
    int n;
    subkey_ready = 1'b1;
    start_sched(KEY_B);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_on got %b want 1", parity_err); end
    checks++; if (np_parity_err !== 1'b0) begin errors++; $display("FAIL parity_off got %b want 0", np_parity_err); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL parity_drain got done=%b want 1", done); end
  endtask

  task automatic test_abort();
    subkey_ready = 1'b1;
    start_sched(KEY_B);  // parity bits are dropped by PC-1, so subkeys match KEY_A
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      checks++; if (round_idx !== 4'(r) || subkey !== k_tab[15-r]) begin errors++; $display("FAIL abort_pre r=%0d got %0d/%h want %0d/%h", r, round_idx, subkey, r, k_tab[15-r]); end
    end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL abort_parity_pre got %b want 1", parity_err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got valid=%b busy=%b done=%b want 0 0 0", subkey_valid, busy, done); end
    checks++; if (round_idx !== 4'd0 || subkey !== 48'h0 || parity_err !== 1'b0) begin errors++; $display("FAIL abort_data got %0d/%h/%b want 0/0/0", round_idx, subkey, parity_err); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (subkey_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d got valid=%b busy=%b want 0 0", c, subkey_valid, busy); end
    end
    start_sched(KEY_A);
    @(negedge clk);
    checks++; if (subkey_valid !== 1'b1 || round_idx !== 4'd0 || subkey !== k_tab[15]) begin errors++; $display("FAIL abort_restart got %b/%0d/%h want 1/0/%h", subkey_valid, round_idx, subkey, k_tab[15]); end
    for (int r = 1; r < 16; r++) @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    int n;
    subkey_ready = 1'b1;
    start_sched(KEY_A);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      checks++; if (round_idx !== 4'(r) || subkey !== k_tab[15-r]) begin errors++; $display("FAIL b2b_seq r=%0d got %0d/%h want %0d/%h", r, round_idx, subkey, r, k_tab[15-r]); end
      start = (r == 5);  // stray start during EMIT
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    start = 1'b1;  // during DONE: ignored
    @(negedge clk);
    checks++; if (busy !== 1'b0 || subkey_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b valid=%b done=%b want 0 0 0", busy, subkey_valid, done); end
    // start still high in IDLE: accepted at the next edge
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || subkey_valid !== 1'b0) begin errors++; $display("FAIL b2b_load got busy=%b valid=%b want 1 0", busy, subkey_valid); end
    @(negedge clk);
    checks++; if (subkey_valid !== 1'b1 || round_idx !== 4'd0 || subkey !== k_tab[15]) begin errors++; $display("FAIL b2b_first got %b/%0d/%h want 1/0/%h", subkey_valid, round_idx, subkey, k_tab[15]); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_drain got done=%b want 1", done); end
  endtask

`ifdef DES_KS_ENC_MODE_EN
  task automatic test_encrypt();
    subkey_ready = 1'b1;
    encrypt = 1'b1;
    start_sched(KEY_A);
    encrypt = 1'b0;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      checks++; if (round_idx !== 4'(r) || subkey !== k_tab[r]) begin errors++; $display("FAIL enc_seq r=%0d got %0d/%h want %0d/%h", r, round_idx, subkey, r, k_tab[r]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL enc_done got %b want 1", done); end
  endtask
`endif

  initial begin
    k_tab[0]  = 48'h1B02EFFC7072; k_tab[1]  = 48'h79AED9DBC9E5;
    k_tab[2]  = 48'h55FC8A42CF99; k_tab[3]  = 48'h72ADD6DB351D;
    k_tab[4]  = 48'h7CEC07EB53A8; k_tab[5]  = 48'h63A53E507B2F;
    k_tab[6]  = 48'hEC84B7F618BC; k_tab[7]  = 48'hF78A3AC13BFB;
    k_tab[8]  = 48'hE0DBEBEDE781; k_tab[9]  = 48'hB1F347BA464F;
    k_tab[10] = 48'h215FD3DED386; k_tab[11] = 48'h7571F59467E9;
    k_tab[12] = 48'h97C5D1FABA41; k_tab[13] = 48'h5F43B7F2E73A;
    k_tab[14] = 48'hBF918D3D3F0A; k_tab[15] = 48'hCB3D8B0E17F5;
`ifdef DES_KS_ENC_MODE_EN
    encrypt = 1'b0;
`endif
    test_reset();
    test_schedule();
    test_stall();
    test_parity();
    test_abort();
    test_back_to_back();
`ifdef DES_KS_ENC_MODE_EN
    test_encrypt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
